fc_act_collector: RTL and testbench
===================================

Name: fc_act_collector

Overview:
- Upstream feeder for a fully-connected layer neuron.
- Accepts a serial stream of WIDTH-bit activations over a valid/ready handshake and assembles IN samples into a parallel vector x[0:IN-1].
- Presents the complete vector with x_valid and holds it stable until the consumer (layer plus its capture logic) accepts it.
- Fully registered; one clock domain.

Parameters:
- WIDTH, 8, activation bit width; must match the layer's WIDTH.
- IN, 128, samples per frame; must match the layer's IN.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  collector can accept a sample.
- in_data  input  WIDTH  activation sample.
- in_last  input  1  marks the final sample of a frame; qualified by in_valid.
- x  output  WIDTH each, unpacked array [0:IN-1]  assembled activation vector; feeds the layer's x.
- x_valid  output  1  x holds a complete frame.
- x_ready  input  1  consumer accepts the frame.
- err_len  output  1  sticky frame-length error.
- frame_cnt  output  16  count of frames handed off; wraps.

Behaviour:
- Clock/reset: single clock clk. Reset is synchronous, active-low on rst_n, sampled on the rising edge.
- Reset values: state=FILL, cnt=0, all x entries=0, x_valid=0, in_ready=0, err_len=0, frame_cnt=0.
  - in_ready rises on the first clock edge after rst_n is sampled high.
- Internals: cnt is $clog2(IN) bits. State is FILL or FULL. All outputs are registered.
- FILL, in_ready=1, x_valid=0:
  - Accept: in_valid && in_ready. On accept, x[cnt] <= in_data and cnt <= cnt+1.
  - Transition to FULL on an accept where cnt==IN-1 or in_last==1.
  - On that edge: x_valid<=1, in_ready<=0, cnt<=0. x_valid is high in the cycle after the final sample is accepted (latency 1).
- FULL, in_ready=0, x_valid=1:
  - x is held bit-stable; in_data is ignored.
  - On x_valid && x_ready: all x entries <= 0, x_valid<=0, in_ready<=1, frame_cnt<=frame_cnt+1, state<=FILL.
  - in_ready never rises in the same cycle as the handoff. Minimum period is IN+1 cycles per frame.
- Short frame: in_last accepted with cnt<IN-1.
  - Frame completes immediately; unwritten entries stay 0 (cleared at the prior handoff or by reset).
  - err_len<=1.
- Long frame: sample accepted at cnt==IN-1 with in_last==0.
  - Frame completes normally; err_len<=1.
  - The following samples start the next frame; no resynchronisation on in_last.
- err_len: sticky; cleared only by reset.
- frame_cnt: wraps 0xFFFF -> 0x0000.
- x_ready while x_valid==0: no effect.
- in_valid while in_ready==0: no effect; upstream must hold the sample.
- Reset mid-frame: partial data is discarded; all registers return to reset values on that edge.
- Consumer timing: the layer is combinational from x. The consumer samples the layer output in the same cycle it asserts x_ready.

Test Plan:
- Reset, then stream 128 samples in_data=k (k=0..127) with in_last on k=127, x_ready=0 -> x_valid=1 exactly one cycle after last accept; x[k]==k; in_ready=0; x is stable for 10 cycles; err_len=0.
- Assert x_ready for 1 cycle -> next cycle: x_valid=0, all x==0, in_ready=1, frame_cnt=1. A second frame of 0xFF samples -> x all 0xFF, frame_cnt=2 after handoff.
- Short frame: 5 samples 0x11 with in_last on the 5th -> x[0..4]=0x11, x[5..127]=0, x_valid=1, err_len=1 and stays 1 across the next clean frame.
- Long frame: 128 samples with no in_last, then 2 more with in_last on the 2nd -> first frame completes at sample 128 with err_len=1. After handoff, a short frame of 2 is delivered: x[0],x[1] set, rest 0.
- Random in_valid (50%) and random x_ready backpressure over 20 frames -> no sample lost or duplicated vs scoreboard; in_ready and x_valid never high together; frame_cnt=20.
- rst_n=0 for one cycle after sample 60 -> next cycle: x all 0, cnt=0, x_valid=0, in_ready=0, err_len=0; in_ready=1 the cycle after rst_n high; a fresh 128-sample frame assembles correctly.

Source files
------------

// File: rtl/fc_act_collector.sv
// Serial-to-parallel activation collector for a fully-connected layer.
// It gathers IN samples into x and holds the vector until the consumer takes it.
module fc_act_collector #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             err_len,
  output logic [15:0]      frame_cnt
);

  localparam int CW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          at_end;

  always_comb begin
    at_end = (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      x         <= '{default: '0};
      x_valid   <= 1'b0;
      in_ready  <= 1'b0;
      err_len   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          // in_ready only comes up a cycle after reset release
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            x[cnt] <= in_data;
            if (at_end || in_last) begin
              state    <= FULL;
              x_valid  <= 1'b1;
              in_ready <= 1'b0;
              cnt      <= '0;
              // short (last before end) or long (end without last) frame
              if (at_end != in_last) begin
                err_len <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FULL: begin
          if (x_ready) begin
            x         <= '{default: '0};
            x_valid   <= 1'b0;
            in_ready  <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_act_collector.sv
// Scoreboard bench for fc_act_collector: stimulus pushes expected frames,
// an independent monitor pops and checks them when x_valid rises.
module tb_fc_act_collector;

  localparam int WIDTH = 8;
  localparam int IN    = 128;

  typedef logic [IN-1:0][WIDTH-1:0] vec_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             x_valid;
  logic             x_ready;
  logic             err_len;
  logic [15:0]      frame_cnt;

  logic xr_dir, xr_rnd, rand_mode;
  assign x_ready = rand_mode ? xr_rnd : xr_dir;

  fc_act_collector #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .x(x), .x_valid(x_valid),
    .x_ready(x_ready), .err_len(err_len), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) xr_rnd <= 1'($urandom_range(0, 1));

  int tests  = 0;
  int failed = 0;
  bit abort  = 0;

  vec_t exp_q[$];
  bit   err_q[$];
  vec_t mvec;
  int   mcnt;
  bit   merr;

  task automatic check(input string name, input bit ok, input string detail);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mvec = '0;
    mcnt = 0;
    merr = 0;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input bit last);
    int n;
    if (abort) return;
    if (rand_mode) while ($urandom_range(0, 1) == 1) step();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 5000) begin
        check("send_timeout", 0, "in_ready never rose within 5000 cycles");
        abort    = 1;
        in_valid = 1'b0;
        return;
      end
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    mvec[mcnt] = d;
    if (mcnt == IN - 1 || last) begin
      if ((mcnt == IN - 1) != last) merr = 1;
      exp_q.push_back(mvec);
      err_q.push_back(merr);
      mvec = '0;
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  task automatic handoff();
    int n;
    n = 0;
    while (!x_valid && n < 5000) begin
      step();
      n++;
    end
    if (!x_valid) begin
      check("handoff_timeout", 0, "x_valid never rose within 5000 cycles");
      return;
    end
    xr_dir = 1'b1;
    step();
    xr_dir = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    int nz;
    nz = 0;
    for (int i = 0; i < IN; i++) if (x[i] !== '0) nz++;
    check({name, "_x"}, nz == 0, $sformatf("nonzero entries %0d, required 0", nz));
    check({name, "_flags"},
          x_valid === 1'b0 && in_ready === 1'b0 && err_len === 1'b0 && frame_cnt === 16'd0,
          $sformatf("x_valid=%b in_ready=%b err_len=%b frame_cnt=%0d, required 0 0 0 0",
                    x_valid, in_ready, err_len, frame_cnt));
  endtask

  // Monitor: frame checks on x_valid rise, stability while held, handoff aftermath.
  initial begin : monitor
    bit          prev, pend, have;
    logic [15:0] fc;
    vec_t        cur;
    bit          e;
    int          bad, first;
    prev = 0; pend = 0; have = 0; fc = '0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 0; pend = 0; have = 0; fc = '0;
        continue;
      end
      if (pend) begin
        pend = 0;
        fc   = fc + 16'd1;
        bad  = 0;
        for (int i = 0; i < IN; i++) if (x[i] !== '0) bad++;
        check("handoff_clear", bad == 0 && x_valid === 1'b0 && in_ready === 1'b1,
              $sformatf("nonzero=%0d x_valid=%b in_ready=%b, required 0 0 1",
                        bad, x_valid, in_ready));
        check("handoff_frame_cnt", frame_cnt === fc,
              $sformatf("frame_cnt=%0d, required %0d", frame_cnt, fc));
      end
      check("ready_valid_overlap", !(in_ready === 1'b1 && x_valid === 1'b1),
            $sformatf("in_ready=%b x_valid=%b, required not both 1", in_ready, x_valid));
      if (x_valid === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 0, "x_valid rose with no frame expected");
          have = 0;
        end else begin
          cur  = exp_q.pop_front();
          e    = err_q.pop_front();
          have = 1;
          check("err_len", err_len === e,
                $sformatf("err_len=%b, required %b", err_len, e));
        end
      end
      if (x_valid === 1'b1 && have) begin
        bad = 0; first = 0;
        for (int i = 0; i < IN; i++) begin
          if (x[i] !== cur[i]) begin
            if (bad == 0) first = i;
            bad++;
          end
        end
        check("frame_data", bad == 0,
              $sformatf("%0d entries wrong, first x[%0d]=%h required %h",
                        bad, first, x[first], cur[first]));
      end
      if (x_valid === 1'b1 && x_ready === 1'b1) pend = 1;
      prev = (x_valid === 1'b1);
    end
  end

  initial begin : stim
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    xr_dir = 1'b0; rand_mode = 1'b0;
    model_clear();

    repeat (3) step();
    @(negedge clk);
    check_reset_state("reset");
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release_early", in_ready === 1'b0,
          $sformatf("in_ready=%b, required 0", in_ready));
    @(negedge clk);
    check("ready_after_release", in_ready === 1'b1,
          $sformatf("in_ready=%b, required 1", in_ready));
    step();

    // Frame of k=0..127, held 10 cycles, then handed off.
    for (int k = 0; k < IN; k++) send(8'(k), k == IN - 1);
    @(negedge clk);
    check("latency", x_valid === 1'b1, $sformatf("x_valid=%b, required 1", x_valid));
    step();
    repeat (10) step();
    handoff();

    // All-ones frame.
    for (int k = 0; k < IN; k++) send(8'hFF, k == IN - 1);
    handoff();

    // Short frame, then a clean frame keeps err_len sticky.
    for (int k = 0; k < 5; k++) send(8'h11, k == 4);
    handoff();
    for (int k = 0; k < IN; k++) send(8'(k) ^ 8'h5A, k == IN - 1);
    handoff();

    // Long frame without in_last, then a two-sample short frame.
    for (int k = 0; k < IN; k++) send(8'(k + 1), 1'b0);
    handoff();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    handoff();

    // Reset after 60 samples of a frame.
    for (int k = 0; k < 60; k++) send(8'(k + 3), 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    check_reset_state("mid_reset");
    @(negedge clk);
    check("mid_reset_ready", in_ready === 1'b1,
          $sformatf("in_ready=%b, required 1", in_ready));
    step();
    for (int k = 0; k < IN; k++) send(8'(255 - k), k == IN - 1);
    handoff();

    // Clean reset, then 20 frames with random gaps and backpressure.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_clear();
    step();
    step();
    rand_mode = 1'b1;
    for (int f = 0; f < 20; f++)
      for (int k = 0; k < IN; k++) send(8'($urandom), k == IN - 1);
    n = 0;
    while ((exp_q.size() != 0 || x_valid === 1'b1) && n < 20000) begin
      step();
      n++;
    end
    rand_mode = 1'b0;
    check("drain", exp_q.size() == 0 && x_valid === 1'b0,
          $sformatf("pending=%0d x_valid=%b, required 0 0", exp_q.size(), x_valid));
    repeat (3) step();
    check("final_frame_cnt", frame_cnt === 16'd20,
          $sformatf("frame_cnt=%0d, required 20", frame_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "timeout");
  end

endmodule
